// File: rtl/mc_control.sv
// mc_control: multi-cycle main control FSM for the MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB for one instruction at a time and drives
// the regfile controls/addresses plus the datapath PC, IR, memory and ALU selects.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   instr[31:0]       current IR contents
//   zero              ALU zero flag
//   mem_ready         memory completes the current request this cycle
//   pc_we, ir_we      PC / IR write enables
//   mem_req, mem_wr   memory request / request is a write
//   iord              memory address select (0 = PC, 1 = ALUOut)
//   rf_we             regfile write enable
//   rf_read1/2        regfile read enables
//   rf_raddr1/2       regfile read addresses (rs, rt)
//   rf_waddr          regfile write address (rd for R-type, rt otherwise)
//   mem_to_reg        writeback source (0 = ALUOut, 1 = MDR)
//   alu_src_a/b       ALU operand selects
//   alu_op            ALU operation (ADD/SUB/AND/OR/SLT)
//   pc_src            PC source (ALU result / ALUOut / jump target)
//   illegal           sticky unsupported-instruction flag
//   state             current state, for debug
module mc_control #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_wr,
    output logic        iord,
    output logic        rf_we,
    output logic        rf_read1,
    output logic        rf_read2,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    output logic [4:0]  rf_waddr,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd7
    } state_e;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAnd = 4'b0010;
    localparam logic [3:0] AluOr  = 4'b0011;
    localparam logic [3:0] AluSlt = 4'b0100;

    state_e state_q;
    logic   illegal_q;

    // Instruction decode
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_rtype_op;
    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_addiu;
    logic       is_j;
    logic       is_legal;
    logic [3:0] r_alu_op;
    logic [4:0] waddr;
    logic       unused_shamt;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        r_alu_op = AluAdd;
        is_r     = 1'b1;
        case (funct)
            6'h21:   r_alu_op = AluAdd;
            6'h23:   r_alu_op = AluSub;
            6'h24:   r_alu_op = AluAnd;
            6'h25:   r_alu_op = AluOr;
            6'h2A:   r_alu_op = AluSlt;
            default: is_r = 1'b0;
        endcase
        is_r = is_r && (opcode == 6'h00);
    end

    assign is_rtype_op = (opcode == 6'h00);
    assign is_lw       = (opcode == 6'h23);
    assign is_sw       = (opcode == 6'h2B);
    assign is_beq      = (opcode == 6'h04);
    assign is_addiu    = (opcode == 6'h09);
    assign is_j        = (opcode == 6'h02);
    assign is_legal    = is_r | is_lw | is_sw | is_beq | is_addiu | is_j;
    assign waddr       = is_rtype_op ? instr[15:11] : instr[20:16];

    // State sequencing; only state and the sticky illegal flag are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= state_e'(RESET_STATE);
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (mem_ready) state_q <= StDecode;
                end
                StDecode: begin
                    if (is_j) begin
                        state_q <= StFetch;
                    end else if (!is_legal) begin
                        state_q   <= StHalt;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (is_lw || is_sw)          state_q <= StMem;
                    else if (is_r || is_addiu)   state_q <= StWb;
                    else                         state_q <= StFetch;
                end
                StMem: begin
                    if (mem_ready) state_q <= is_sw ? StFetch : StWb;
                end
                StWb:    state_q <= StFetch;
                StHalt:  state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Outputs are combinational from state and the live inputs; reset forces them low.
    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        rf_we      = 1'b0;
        rf_read1   = 1'b0;
        rf_read2   = 1'b0;
        rf_raddr1  = 5'd0;
        rf_raddr2  = 5'd0;
        rf_waddr   = 5'd0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = AluAdd;
        pc_src     = 2'b00;
        illegal    = illegal_q;
        state      = state_q;

        if (!rst && state_q != StHalt) begin
            rf_raddr1 = instr[25:21];
            rf_raddr2 = instr[20:16];
            rf_waddr  = waddr;
            case (state_q)
                StFetch: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                StDecode: begin
                    rf_read1  = 1'b1;
                    rf_read2  = 1'b1;
                    alu_src_b = 2'b11;
                    if (is_j) begin
                        pc_we  = 1'b1;
                        pc_src = 2'b10;
                    end
                end
                StExec: begin
                    alu_src_a = 1'b1;
                    if (is_r) begin
                        alu_op = r_alu_op;
                    end else if (is_beq) begin
                        alu_op = AluSub;
                        pc_src = 2'b01;
                        pc_we  = zero;
                    end else begin
                        alu_src_b = 2'b10;
                    end
                end
                StMem: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_wr  = is_sw;
                end
                StWb: begin
                    // Never write $0
                    rf_we      = (waddr != 5'd0);
                    mem_to_reg = is_lw;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_we, ir_we, mem_req, mem_wr, iord, rf_we, rf_read1, rf_read2;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [3:0]  alu_op;
    logic        illegal;
    logic [2:0]  state;

    mc_control dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .iord      (iord),
        .rf_we     (rf_we),
        .rf_read1  (rf_read1),
        .rf_read2  (rf_read2),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_waddr  (rf_waddr),
        .mem_to_reg(mem_to_reg),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .pc_src    (pc_src),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- Behavioural model ----------------
    // Each instruction class is a fixed list of states it walks through; the model
    // keeps an index into that list and only stalls in FETCH/MEM without mem_ready.
    localparam int CR = 0, CLW = 1, CSW = 2, CBEQ = 3, CADDI = 4, CJ = 5, CILL = 6;
    int seq_st [7][5] = '{'{0, 1, 2, 4, 0}, '{0, 1, 2, 3, 4}, '{0, 1, 2, 3, 0},
                          '{0, 1, 2, 0, 0}, '{0, 1, 2, 4, 0}, '{0, 1, 0, 0, 0},
                          '{0, 1, 7, 0, 0}};
    int seq_len [7] = '{4, 5, 4, 3, 4, 2, 3};
    int m_idx = 0;
    int m_st;

    function automatic int cls_of(input logic [31:0] i);
        case (i[31:26])
            6'h00: begin
                if (i[5:0] inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2A}) return CR;
                return CILL;
            end
            6'h23:   return CLW;
            6'h2B:   return CSW;
            6'h04:   return CBEQ;
            6'h09:   return CADDI;
            6'h02:   return CJ;
            default: return CILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'h23:   return 4'd1;
            6'h24:   return 4'd2;
            6'h25:   return 4'd3;
            6'h2A:   return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [36:0] model_out(input int st, input logic [31:0] i,
                                              input logic z, input logic mr, input logic r);
        logic pcwe, irwe, req, wr, io, rfwe, rd1, rd2, m2r, sa, ill;
        logic [4:0] ra1, ra2, wa;
        logic [1:0] sb, ps;
        logic [3:0] op;
        logic [2:0] s;
        int c;
        {pcwe, irwe, req, wr, io, rfwe, rd1, rd2, m2r, sa, ill} = '0;
        {ra1, ra2, wa, sb, ps, op} = '0;
        c = cls_of(i);
        s = r ? 3'd0 : 3'(st);
        if (!r && st != 7) begin
            ra1 = i[25:21];
            ra2 = i[20:16];
            wa  = (i[31:26] == 6'h00) ? i[15:11] : i[20:16];
        end
        if (!r) begin
            case (st)
                0: begin req = 1; sb = 2'd1; pcwe = mr; irwe = mr; end
                1: begin
                    rd1 = 1; rd2 = 1; sb = 2'd3;
                    if (c == CJ) begin pcwe = 1; ps = 2'd2; end
                end
                2: begin
                    sa = 1;
                    if (c == CR) op = alu_of(i[5:0]);
                    else if (c == CBEQ) begin op = 4'd1; ps = 2'd1; pcwe = z; end
                    else sb = 2'd2;
                end
                3: begin req = 1; io = 1; wr = (c == CSW); end
                4: begin rfwe = (wa != 5'd0); m2r = (c == CLW); end
                7: ill = 1;
                default: ;
            endcase
        end
        return {pcwe, irwe, req, wr, io, rfwe, rd1, rd2, ra1, ra2, wa, m2r, sa, sb, op, ps, ill, s};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx <= 0;
        end else begin
            if (seq_st[cls_of(instr)][m_idx] == 7) m_idx <= m_idx;
            else if ((seq_st[cls_of(instr)][m_idx] == 0 || seq_st[cls_of(instr)][m_idx] == 3)
                     && !mem_ready) m_idx <= m_idx;
            else if (m_idx + 1 == seq_len[cls_of(instr)]) m_idx <= 0;
            else m_idx <= m_idx + 1;
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        m_st = seq_st[cls_of(instr)][m_idx];
        check("cycle outputs",
              {pc_we, ir_we, mem_req, mem_wr, iord, rf_we, rf_read1, rf_read2, rf_raddr1,
               rf_raddr2, rf_waddr, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal, state},
              model_out(m_st, instr, zero, mem_ready, rst));
    end

    // ---------------- Directed stimulus ----------------
    logic [2:0] st_log [16];
    logic       req_log [16], iord_log [16], pcwe_log [16], wr_log [16];
    logic       rfwe_log [16], m2r_log [16], rd1_log [16];
    logic [1:0] pcsrc_log [16];
    logic [3:0] op_log [16];
    logic [4:0] wa_log [16];

    task automatic run(input logic [31:0] ins, input int n, input logic [15:0] mr,
                       input logic [15:0] z);
        instr = ins;
        for (int c = 0; c < n; c++) begin
            mem_ready = mr[c];
            zero      = z[c];
            @(negedge clk);
            st_log[c]    = state;    req_log[c]   = mem_req;  iord_log[c] = iord;
            pcwe_log[c]  = pc_we;    wr_log[c]    = mem_wr;   rfwe_log[c] = rf_we;
            m2r_log[c]   = mem_to_reg; rd1_log[c] = rf_read1; pcsrc_log[c] = pc_src;
            op_log[c]    = alu_op;   wa_log[c]    = rf_waddr;
            @(posedge clk);
            #1;
        end
    endtask

    int n_req;
    logic [5:0]  fn_list [4] = '{6'h23, 6'h24, 6'h25, 6'h2A};
    logic [3:0]  op_list [4] = '{4'd1, 4'd2, 4'd3, 4'd4};

    initial begin
        rst = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset state", state, 3'd0);
        check("reset mem_req", mem_req, 1'b0);
        check("reset illegal", illegal, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // addu $3,$1,$2
        run(32'h00221821, 4, 16'hFFFF, 16'h0);
        check("addu states", {st_log[0], st_log[1], st_log[2], st_log[3]}, 12'o0124);
        check("addu wb rf_we", rfwe_log[3], 1'b1);
        check("addu wb waddr", wa_log[3], 5'd3);
        check("addu exec op", op_log[2], 4'd0);
        check("addu read1 only decode", {rd1_log[0], rd1_log[1], rd1_log[2], rd1_log[3]}, 4'b0100);
        check("addu back to fetch", state, 3'd0);

        // lw $5,8($4) with two MEM wait cycles
        run(32'h8C850008, 7, 16'h0067, 16'h0);
        check("lw states", {st_log[0], st_log[1], st_log[2], st_log[3], st_log[4], st_log[5],
                            st_log[6]}, 21'o0123334);
        n_req = 0;
        for (int c = 0; c < 7; c++) if (req_log[c] && iord_log[c]) n_req++;
        check("lw mem_req iord cycles", n_req, 3);
        check("lw mem_to_reg", m2r_log[6], 1'b1);
        check("lw waddr", wa_log[6], 5'd5);
        check("lw done in 7", state, 3'd0);

        // beq taken then not taken
        run(32'h10220004, 3, 16'hFFFF, 16'hFFFF);
        check("beq z1 pc_we", pcwe_log[2], 1'b1);
        check("beq z1 pc_src", pcsrc_log[2], 2'd1);
        check("beq z1 states", {st_log[0], st_log[1], st_log[2]}, 9'o012);
        check("beq z1 back to fetch", state, 3'd0);
        run(32'h10220004, 3, 16'hFFFF, 16'h0);
        check("beq z0 pc_we", pcwe_log[2], 1'b0);
        check("beq z0 back to fetch", state, 3'd0);

        // addiu $0,$0,5: write to $0 suppressed
        run(32'h24000005, 4, 16'hFFFF, 16'h0);
        check("addiu wb state", st_log[3], 3'd4);
        check("addiu waddr", wa_log[3], 5'd0);
        check("addiu rf_we", rfwe_log[3], 1'b0);

        // j
        run(32'h08000010, 2, 16'hFFFF, 16'h0);
        check("j pc_we", pcwe_log[1], 1'b1);
        check("j pc_src", pcsrc_log[1], 2'd2);
        check("j back to fetch", state, 3'd0);

        // remaining R-type alu_op decodes
        for (int k = 0; k < 4; k++) begin
            run({26'h0088C60, fn_list[k]}, 4, 16'hFFFF, 16'h0);
            check("rtype alu_op", op_log[2], op_list[k]);
        end

        // sw without waits
        run(32'hAC850008, 4, 16'hFFFF, 16'h0);
        check("sw mem_wr", wr_log[3], 1'b1);
        check("sw mem state", st_log[3], 3'd3);
        check("sw back to fetch", state, 3'd0);

        // illegal op 0x3F
        run(32'hFC000000, 3, 16'hFFFF, 16'h0);
        check("illegal halt", st_log[2], 3'd7);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("halt state", state, 3'd7);
            check("halt mem_req", mem_req, 1'b0);
            check("halt illegal", illegal, 1'b1);
        end
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("rst clears illegal", illegal, 1'b0);
        check("rst state", state, 3'd0);
        @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("fetch after halt", mem_req, 1'b1);
        @(posedge clk); #1;

        // sw with reset pulsed during a MEM wait
        run(32'hAC850008, 4, 16'h0007, 16'h0);
        mem_ready = 1'b0;
        check("sw waiting mem_req", mem_req, 1'b1);
        check("sw waiting state", state, 3'd3);
        #2 rst = 1'b1;
        #1;
        check("rst drops mem_req", mem_req, 1'b0);
        check("rst mid mem state", state, 3'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("refetch state", state, 3'd0);
        check("refetch mem_req", mem_req, 1'b1);
        check("refetch iord", iord, 1'b0);
        @(posedge clk); #1;

        // R-type with unsupported funct is illegal
        run(32'h00000000, 3, 16'hFFFF, 16'h0);
        check("bad funct halt", st_log[2], 3'd7);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
